// File: rtl/frame_cmd_tx.sv
// Command/payload byte serializer: emits a command byte, then payload fetched from source RAM.
// Latency: byte_vld_o rises the cycle CMD/SEND is entered; 2-cycle FETCH/WAIT bubble per source word.
// Backpressure: byte_vld_o/dc_o/byte_data_o hold while byte_rdy_i is low; the FSM advances only on acceptance.
module frame_cmd_tx (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [7:0]  chan_len_i,
   input  logic [3:0]  chan_cnt_i,
   output logic        src_rd_en_o,
   output logic [3:0]  src_rd_chan_o,
   output logic [7:0]  src_rd_addr_o,
   input  logic [31:0] src_rd_data_i,
   output logic        dc_o,
   output logic        byte_vld_o,
   input  logic        byte_rdy_i,
   output logic [7:0]  byte_data_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [1:0] OP_CONF = 2'd0;
   localparam logic [1:0] OP_ADDR = 2'd1;
   localparam logic [1:0] OP_DATA = 2'd2;
   localparam logic [1:0] OP_ILL  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_FETCH,
      ST_WAIT,
      ST_SEND,
      ST_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  op_q;
   logic [7:0]  len_q;
   logic [3:0]  cnt_q;
   logic [3:0]  c_q, c_d;
   logic [7:0]  w_q, w_d;
   logic [1:0]  lane_q, lane_d;
   logic [31:0] word_q;
   logic        load_params;
   logic        last_lane;

   // A word yields 3 bytes for DATA_WR, 1 for ADDR_WR; CONF_WR uses the lane index for its 2 fixed bytes.
   always_comb begin
      last_lane = 1'b1;
      if (op_q == OP_DATA) begin
         last_lane = (lane_q == 2'd2);
      end else if (op_q == OP_CONF) begin
         last_lane = (lane_q == 2'd1);
      end
   end

   // Next-state, counter-advance and output decode; all outputs are a function of registered state,
   // so the asynchronous reset forces every output to zero immediately.
   always_comb begin
      state_d       = state_q;
      c_d           = c_q;
      w_d           = w_q;
      lane_d        = lane_q;
      load_params   = 1'b0;
      src_rd_en_o   = 1'b0;
      src_rd_chan_o = 4'h0;
      src_rd_addr_o = 8'h00;
      dc_o          = 1'b0;
      byte_vld_o    = 1'b0;
      byte_data_o   = 8'h00;
      busy_o        = (state_q != ST_IDLE) && (state_q != ST_DONE);
      done_o        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               load_params = 1'b1;
               c_d         = 4'h0;
               w_d         = 8'h00;
               lane_d      = 2'd0;
               state_d     = (op_i == OP_ILL) ? ST_DONE : ST_CMD;
            end
         end
         ST_CMD: begin
            byte_vld_o  = 1'b1;
            byte_data_o = 8'h2A + {6'd0, op_q};
            if (byte_rdy_i) begin
               state_d = (op_q == OP_CONF) ? ST_SEND : ST_FETCH;
            end
         end
         ST_FETCH: begin
            src_rd_en_o   = 1'b1;
            src_rd_chan_o = c_q;
            src_rd_addr_o = w_q;
            state_d       = ST_WAIT;
         end
         ST_WAIT: begin
            state_d = ST_SEND;
         end
         ST_SEND: begin
            byte_vld_o = 1'b1;
            dc_o       = 1'b1;
            case (op_q)
               OP_CONF: byte_data_o = (lane_q == 2'd0) ? len_q : {4'h0, cnt_q};
               OP_ADDR: byte_data_o = word_q[31:24];
               OP_DATA: begin
                  case (lane_q)
                     2'd0:    byte_data_o = word_q[23:16];
                     2'd1:    byte_data_o = word_q[15:8];
                     default: byte_data_o = word_q[7:0];
                  endcase
               end
               default: byte_data_o = 8'h00;
            endcase
            if (byte_rdy_i) begin
               if (!last_lane) begin
                  lane_d = lane_q + 2'd1;
               end else begin
                  lane_d = 2'd0;
                  if (op_q == OP_CONF) begin
                     state_d = ST_DONE;
                  end else if (w_q == len_q) begin
                     if (c_q == cnt_q) begin
                        state_d = ST_DONE;
                     end else begin
                        c_d     = c_q + 4'd1;
                        w_d     = 8'h00;
                        state_d = ST_FETCH;
                     end
                  end else begin
                     w_d     = w_q + 8'd1;
                     state_d = ST_FETCH;
                  end
               end
            end
         end
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; parameters are latched only when a transfer is accepted in IDLE.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         op_q    <= 2'd0;
         len_q   <= 8'h00;
         cnt_q   <= 4'h0;
         c_q     <= 4'h0;
         w_q     <= 8'h00;
         lane_q  <= 2'd0;
         word_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         w_q     <= w_d;
         lane_q  <= lane_d;
         if (load_params) begin
            op_q  <= op_i;
            len_q <= chan_len_i;
            cnt_q <= chan_cnt_i;
         end
         if (state_q == ST_WAIT) begin
            word_q <= src_rd_data_i;
         end
      end
   end

endmodule

// File: tb/tb_frame_cmd_tx.sv
// Bench for frame_cmd_tx: source RAM model, random ready, byte/read scoreboards.
module tb_frame_cmd_tx;

   logic        clk_i;
   logic        rst_n_i;
   logic        start_i;
   logic [1:0]  op_i;
   logic [7:0]  chan_len_i;
   logic [3:0]  chan_cnt_i;
   logic        src_rd_en_o;
   logic [3:0]  src_rd_chan_o;
   logic [7:0]  src_rd_addr_o;
   logic [31:0] src_rd_data_i;
   logic        dc_o;
   logic        byte_vld_o;
   logic        byte_rdy_i;
   logic [7:0]  byte_data_o;
   logic        busy_o;
   logic        done_o;

   frame_cmd_tx dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .start_i       (start_i),
      .op_i          (op_i),
      .chan_len_i    (chan_len_i),
      .chan_cnt_i    (chan_cnt_i),
      .src_rd_en_o   (src_rd_en_o),
      .src_rd_chan_o (src_rd_chan_o),
      .src_rd_addr_o (src_rd_addr_o),
      .src_rd_data_i (src_rd_data_i),
      .dc_o          (dc_o),
      .byte_vld_o    (byte_vld_o),
      .byte_rdy_i    (byte_rdy_i),
      .byte_data_o   (byte_data_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   typedef struct packed { logic dc; logic [7:0] dat; } byte_t;
   typedef struct packed { logic [3:0] chan; logic [7:0] addr; } rd_t;

   byte_t       exp_q[$];
   rd_t         rd_q[$];
   logic [31:0] mem [16][256];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          rdy_pct = 100;
   int          n_bytes = 0;
   int          n_reads = 0;
   int          n_done = 0;
   logic [3:0]  last_c;
   logic [7:0]  last_w;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: the byte stream and read sequence a transfer must produce.
   task automatic push_expect(input logic [1:0] op, input logic [7:0] len, input logic [3:0] cnt,
                              output int nrd);
      byte_t b;
      rd_t   r;
      logic [31:0] word;
      nrd = 0;
      if (op == 2'd3) return;
      b.dc = 1'b0; b.dat = 8'h2A + 8'(op); exp_q.push_back(b);
      if (op == 2'd0) begin
         b.dc = 1'b1; b.dat = len;          exp_q.push_back(b);
         b.dc = 1'b1; b.dat = {4'h0, cnt};  exp_q.push_back(b);
         return;
      end
      for (int c = 0; c <= int'(cnt); c++) begin
         for (int w = 0; w <= int'(len); w++) begin
            r.chan = 4'(c); r.addr = 8'(w); rd_q.push_back(r);
            nrd++;
            word = mem[c][w];
            b.dc = 1'b1;
            if (op == 2'd1) begin
               b.dat = word[31:24]; exp_q.push_back(b);
            end else begin
               b.dat = word[23:16]; exp_q.push_back(b);
               b.dat = word[15:8];  exp_q.push_back(b);
               b.dat = word[7:0];   exp_q.push_back(b);
            end
         end
      end
   endtask

   task automatic fill_random();
      for (int c = 0; c < 16; c++)
         for (int w = 0; w < 256; w++)
            mem[c][w] = $urandom;
   endtask

   task automatic fill_pattern();
      for (int c = 0; c < 16; c++)
         for (int w = 0; w < 256; w++)
            mem[c][w] = {8'(c), 8'(w), 8'hA5, 8'h5A};
   endtask

   // Transmitter ready, re-drawn each cycle.
   initial begin
      byte_rdy_i = 1'b0;
      forever begin
         @(posedge clk_i); #1;
         byte_rdy_i = (int'($urandom_range(99)) < rdy_pct);
      end
   end

   // Source RAM: data appears only in the cycle after the read strobe, otherwise garbage.
   initial begin
      logic       pend;
      logic [3:0] pc;
      logic [7:0] pa;
      src_rd_data_i = 32'h0;
      forever begin
         @(negedge clk_i);
         pend = src_rd_en_o; pc = src_rd_chan_o; pa = src_rd_addr_o;
         @(posedge clk_i); #1;
         src_rd_data_i = pend ? mem[pc][pa] : $urandom;
      end
   end

   // Monitor: pops scoreboards on reads and accepted bytes, checks stall stability.
   initial begin
      logic  stall;
      byte_t prev, got, e;
      rd_t   r;
      stall = 1'b0;
      prev  = '0;
      forever begin
         @(negedge clk_i);
         if (!rst_n_i) begin
            stall = 1'b0;
         end else begin
            if (stall) check("stall_hold", {byte_vld_o, dc_o, byte_data_o}, {1'b1, prev.dc, prev.dat});
            if (src_rd_en_o) begin
               check("rd_excl_vld", byte_vld_o, 1'b0);
               n_reads++; last_c = src_rd_chan_o; last_w = src_rd_addr_o;
               check("rd_expected", rd_q.size() != 0, 1'b1);
               if (rd_q.size() != 0) begin
                  r = rd_q.pop_front();
                  check("rd_chan_addr", {src_rd_chan_o, src_rd_addr_o}, {r.chan, r.addr});
               end
            end
            if (byte_vld_o && byte_rdy_i) begin
               n_bytes++;
               got.dc = dc_o; got.dat = byte_data_o;
               check("byte_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("byte_dc_data", got, e);
               end
            end
            if (done_o) begin
               n_done++;
               check("done_busy_low", {busy_o, byte_vld_o}, 2'b00);
            end
            stall   = byte_vld_o && !byte_rdy_i;
            prev.dc = dc_o; prev.dat = byte_data_o;
         end
      end
   end

   // One complete transfer; poke pulses start and scrambles inputs while busy.
   task automatic run(input logic [1:0] op, input logic [7:0] len, input logic [3:0] cnt,
                      input int pct, input bit poke);
      int nrd, d0, r0, cyc;
      bit seen;
      rdy_pct = pct;
      push_expect(op, len, cnt, nrd);
      d0 = n_done; r0 = n_reads;
      @(posedge clk_i); #1;
      start_i = 1'b1; op_i = op; chan_len_i = len; chan_cnt_i = cnt;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      op_i = 2'($urandom_range(3)); chan_len_i = 8'($urandom); chan_cnt_i = 4'($urandom);
      check("busy_after_start", busy_o, op != 2'd3);
      check("done_after_start", done_o, op == 2'd3);
      seen = (op == 2'd3) && done_o;
      cyc = 0;
      while (!seen && cyc < 30000) begin
         @(negedge clk_i);
         cyc++;
         if (poke) begin
            start_i = (cyc % 7 == 3);
            op_i = 2'($urandom_range(3)); chan_len_i = 8'($urandom); chan_cnt_i = 4'($urandom);
         end
         if (done_o) seen = 1'b1;
      end
      start_i = 1'b0;
      check("done_seen", seen, 1'b1);
      repeat (4) @(negedge clk_i);
      check("done_count", n_done - d0, 1);
      check("bytes_left", exp_q.size(), 0);
      check("reads_left", rd_q.size(), 0);
      check("read_count", n_reads - r0, nrd);
      check("idle_outputs", {busy_o, byte_vld_o, src_rd_en_o, done_o}, 4'b0000);
      exp_q.delete(); rd_q.delete();
   endtask

   initial begin
      int b0, d0, r0, cyc, nrd;
      rst_n_i = 1'b0; start_i = 1'b0; op_i = 2'd0; chan_len_i = 8'h0; chan_cnt_i = 4'h0;
      fill_random();
      repeat (3) @(negedge clk_i);
      check("reset_outputs", {byte_vld_o, dc_o, byte_data_o, src_rd_en_o, src_rd_chan_o,
                              src_rd_addr_o, busy_o, done_o}, 0);
      rst_n_i = 1'b1;
      repeat (2) @(negedge clk_i);
      check("post_reset_idle", {busy_o, byte_vld_o, done_o}, 3'b000);

      // CONF_WR fixed payload, ready always high
      run(2'd0, 8'h3F, 4'd7, 100, 1'b0);
      // DATA_WR with {c,w,A5,5A} words
      fill_pattern();
      run(2'd2, 8'd1, 4'd1, 100, 1'b0);
      // ADDR_WR under 30% ready
      fill_random();
      run(2'd1, 8'd2, 4'd0, 30, 1'b0);
      // Illegal op: done only
      r0 = n_bytes;
      run(2'd3, 8'd5, 4'd2, 100, 1'b0);
      check("illegal_no_bytes", n_bytes - r0, 0);
      // Starts during a busy DATA_WR must be ignored
      run(2'd2, 8'd3, 4'd2, 60, 1'b1);
      // Minimum sizes
      run(2'd1, 8'd0, 4'd0, 50, 1'b0);
      run(2'd2, 8'd0, 4'd0, 50, 1'b0);
      // Randomized transfers
      for (int i = 0; i < 8; i++) begin
         fill_random();
         run(2'($urandom_range(3)), 8'($urandom_range(5)), 4'($urandom_range(3)),
             int'($urandom_range(100, 30)), 1'($urandom_range(1)));
      end
      // Maximum DATA_WR
      b0 = n_bytes;
      run(2'd2, 8'd255, 4'd15, 100, 1'b0);
      check("max_bytes", n_bytes - b0, 1 + 12288);
      check("max_last_read", {last_c, last_w}, {4'd15, 8'd255});

      // Rerun max, reset after 100 accepted bytes
      rdy_pct = 100;
      push_expect(2'd2, 8'd255, 4'd15, nrd);
      b0 = n_bytes; d0 = n_done;
      @(posedge clk_i); #1;
      start_i = 1'b1; op_i = 2'd2; chan_len_i = 8'd255; chan_cnt_i = 4'd15;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      cyc = 0;
      while ((n_bytes - b0) < 100 && cyc < 2000) begin
         @(negedge clk_i);
         cyc++;
      end
      check("reached_byte_100", (n_bytes - b0) >= 100, 1'b1);
      #2 rst_n_i = 1'b0;
      #1 check("async_reset_outputs", {byte_vld_o, dc_o, byte_data_o, src_rd_en_o, src_rd_chan_o,
                                        src_rd_addr_o, busy_o, done_o}, 0);
      repeat (3) @(negedge clk_i);
      exp_q.delete(); rd_q.delete();
      rst_n_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check("abort_no_done", n_done - d0, 0);
      check("abort_idle", {busy_o, byte_vld_o}, 2'b00);
      fill_random();
      run(2'd1, 8'd4, 4'd1, 70, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
